// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station and its execute unit.
// Latency: none (constants only).
// Backpressure: not applicable.
//
// Opcode numbering is shared with the Decoder; tag 0 means "operand already present".
package alu_rs_pkg;

    localparam int OP_NOP  = 0;
    localparam int OP_ADD  = 1;
    localparam int OP_SUB  = 2;
    localparam int OP_SLT  = 3;
    localparam int OP_SLTU = 4;
    localparam int OP_XOR  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_AND  = 7;
    localparam int OP_SLL  = 8;
    localparam int OP_SRL  = 9;
    localparam int OP_SRA  = 10;

    localparam int REG_NO_LOCK = 0;

endpackage

// File: rtl/alu_rs_exec.sv
// Combinational ALU: opcode plus two operands to one DATA_W result.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
//
// Ports: op (opcode), a/b (operands), result (wrap-around result; 0 for undefined opcodes).
module alu_rs_exec
    import alu_rs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] sh;

    assign sh = b[SH_W-1:0];

    always_comb begin
        result = '0;
        case (int'(op))
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLT:  result = DATA_W'($signed(a) < $signed(b));
            OP_SLTU: result = DATA_W'(a < b);
            OP_XOR:  result = a ^ b;
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            OP_SLL:  result = a << sh;
            OP_SRL:  result = a >> sh;
            OP_SRA:  result = DATA_W'($signed(a) >>> sh);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_rs_ooo.sv
// ALU reservation station + execute: buffers ops, wakes operands from the CDB, issues oldest ready op.
// Latency: fully-ready op dispatched at edge t appears on cdb_out after edge t+1.
// Backpressure: disp_stall when full; result held while cdb_out_valid && !cdb_out_ready, issue waits.
//
// Ports: clk/rst (async active-low); disp_* dispatch from the Decoder, disp_stall/occupancy status;
// cdb_in_* broadcast snoop; cdb_out_* result towards the CDB arbiter (cdb_out_ready = grant); flush.
module alu_rs_ooo
    import alu_rs_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int LOCK_W = 5,
    parameter int OP_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    disp_valid,
    input  logic [OP_W-1:0]         disp_op,
    input  logic [DATA_W-1:0]       disp_data1,
    input  logic [LOCK_W-1:0]       disp_lock1,
    input  logic [DATA_W-1:0]       disp_data2,
    input  logic [LOCK_W-1:0]       disp_lock2,
    input  logic [LOCK_W-1:0]       disp_rd_lock,
    output logic                    disp_stall,
    output logic [$clog2(DEPTH):0]  occupancy,
    input  logic                    cdb_in_valid,
    input  logic [LOCK_W-1:0]       cdb_in_index,
    input  logic [DATA_W-1:0]       cdb_in_result,
    output logic                    cdb_out_valid,
    output logic [LOCK_W-1:0]       cdb_out_index,
    output logic [DATA_W-1:0]       cdb_out_result,
    input  logic                    cdb_out_ready,
    input  logic                    flush
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] data1;
        logic [LOCK_W-1:0] lock1;
        logic [DATA_W-1:0] data2;
        logic [LOCK_W-1:0] lock2;
        logic [LOCK_W-1:0] rd_lock;
    } entry_t;

    entry_t            ent_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    // older_q[j][i] set means entry j was dispatched before entry i.
    logic [DEPTH-1:0]  older_q [DEPTH];

    logic [DEPTH-1:0]  rdy;
    logic [DEPTH-1:0]  gnt;
    logic [IDX_W-1:0]  free_idx;
    logic [CNT_W-1:0]  cnt;
    entry_t            sel_ent;
    entry_t            new_ent;
    logic [DATA_W-1:0] exec_res;
    logic              snoop_en;
    logic              issue_fire;
    logic              disp_fire;

    assign snoop_en = cdb_in_valid && (cdb_in_index != LOCK_W'(REG_NO_LOCK));

    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) cnt = cnt + CNT_W'(vld_q[i]);
    end

    assign occupancy  = cnt;
    assign disp_stall = (cnt == CNT_W'(DEPTH));

    // Lowest-index free slot; only meaningful when not stalled.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vld_q[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = vld_q[i] && (ent_q[i].lock1 == '0) && (ent_q[i].lock2 == '0);
        end
    end

    // An entry wins when no other ready entry is older than it; at most one bit survives.
    always_comb begin
        gnt = rdy;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && rdy[j] && older_q[j][i]) gnt[i] = 1'b0;
            end
        end
    end

    always_comb begin
        sel_ent = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (gnt[i]) sel_ent = ent_q[i];
        end
    end

    assign issue_fire = (|rdy) && (!cdb_out_valid || cdb_out_ready) && !flush;
    assign disp_fire  = disp_valid && !disp_stall && !flush;

    // Incoming op catches a broadcast happening in its own dispatch cycle.
    always_comb begin
        new_ent.op      = disp_op;
        new_ent.data1   = disp_data1;
        new_ent.lock1   = disp_lock1;
        new_ent.data2   = disp_data2;
        new_ent.lock2   = disp_lock2;
        new_ent.rd_lock = disp_rd_lock;
        if (snoop_en && disp_lock1 == cdb_in_index) begin
            new_ent.data1 = cdb_in_result;
            new_ent.lock1 = '0;
        end
        if (snoop_en && disp_lock2 == cdb_in_index) begin
            new_ent.data2 = cdb_in_result;
            new_ent.lock2 = '0;
        end
    end

    alu_rs_exec #(.DATA_W(DATA_W), .OP_W(OP_W)) u_exec (
        .op     (sel_ent.op),
        .a      (sel_ent.data1),
        .b      (sel_ent.data2),
        .result (exec_res)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else if (flush) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (snoop_en && ent_q[i].lock1 == cdb_in_index) begin
                    ent_q[i].data1 <= cdb_in_result;
                    ent_q[i].lock1 <= '0;
                end
                if (snoop_en && ent_q[i].lock2 == cdb_in_index) begin
                    ent_q[i].data2 <= cdb_in_result;
                    ent_q[i].lock2 <= '0;
                end
                if (issue_fire && gnt[i]) vld_q[i] <= 1'b0;
            end
            // Target slot is free in registered state, so it never collides with the issuing slot.
            if (disp_fire) begin
                ent_q[free_idx] <= new_ent;
                vld_q[free_idx] <= 1'b1;
                for (int j = 0; j < DEPTH; j++) older_q[j][free_idx] <= vld_q[j];
                older_q[free_idx] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_out_valid  <= 1'b0;
            cdb_out_index  <= '0;
            cdb_out_result <= '0;
        end else if (flush) begin
            cdb_out_valid  <= 1'b0;
            cdb_out_index  <= '0;
            cdb_out_result <= '0;
        end else if (issue_fire) begin
            cdb_out_valid  <= 1'b1;
            cdb_out_index  <= sel_ent.rd_lock;
            cdb_out_result <= exec_res;
        end else if (cdb_out_valid && cdb_out_ready) begin
            cdb_out_valid  <= 1'b0;
            cdb_out_index  <= '0;
            cdb_out_result <= '0;
        end
    end

endmodule

// File: tb/tb_alu_rs_ooo.sv
// Bench for alu_rs_ooo: directed scenarios plus randomized traffic against an age-ordered queue model.
// Inputs change on the falling edge; outputs are compared on the falling edge after each rising edge.
module tb_alu_rs_ooo;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int LOCK_W = 5;
    localparam int OP_W   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        disp_valid;
    logic [3:0]  disp_op;
    logic [31:0] disp_data1;
    logic [4:0]  disp_lock1;
    logic [31:0] disp_data2;
    logic [4:0]  disp_lock2;
    logic [4:0]  disp_rd_lock;
    logic        disp_stall;
    logic [2:0]  occupancy;
    logic        cdb_in_valid;
    logic [4:0]  cdb_in_index;
    logic [31:0] cdb_in_result;
    logic        cdb_out_valid;
    logic [4:0]  cdb_out_index;
    logic [31:0] cdb_out_result;
    logic        cdb_out_ready;
    logic        flush;

    always #5 clk = ~clk;

    alu_rs_ooo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .LOCK_W(LOCK_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_op(disp_op),
        .disp_data1(disp_data1), .disp_lock1(disp_lock1),
        .disp_data2(disp_data2), .disp_lock2(disp_lock2),
        .disp_rd_lock(disp_rd_lock), .disp_stall(disp_stall), .occupancy(occupancy),
        .cdb_in_valid(cdb_in_valid), .cdb_in_index(cdb_in_index), .cdb_in_result(cdb_in_result),
        .cdb_out_valid(cdb_out_valid), .cdb_out_index(cdb_out_index),
        .cdb_out_result(cdb_out_result), .cdb_out_ready(cdb_out_ready), .flush(flush)
    );

    // Model: a queue kept in dispatch order, so the front-most ready element is the oldest ready op.
    typedef struct {
        logic [3:0]  op;
        logic [31:0] d1;
        logic [4:0]  l1;
        logic [31:0] d2;
        logic [4:0]  l2;
        logic [4:0]  rd;
    } m_ent_t;

    m_ent_t      mq[$];
    logic        m_v   = 1'b0;
    logic [4:0]  m_idx = '0;
    logic [31:0] m_res = '0;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            // Signed order equals unsigned order once both sign bits are flipped.
            4'd3:    return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a | b;
            4'd7:    return a & b;
            4'd8:    return a << sh;
            4'd9:    return a >> sh;
            4'd10:   return a[31] ? ~((~a) >> sh) : (a >> sh);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        int     sel;
        bit     iss;
        bit     can_disp;
        bit     snoop;
        m_ent_t e;
        sel = -1;
        foreach (mq[i]) if (sel < 0 && mq[i].l1 == 0 && mq[i].l2 == 0) sel = i;
        snoop    = cdb_in_valid && (cdb_in_index != 0);
        can_disp = disp_valid && (mq.size() < DEPTH);
        if (flush) begin
            mq.delete();
            m_v = 1'b0;
        end else begin
            iss = (sel >= 0) && (!m_v || cdb_out_ready);
            if (iss) begin
                m_v   = 1'b1;
                m_idx = mq[sel].rd;
                m_res = ref_alu(mq[sel].op, mq[sel].d1, mq[sel].d2);
                mq.delete(sel);
            end else if (m_v && cdb_out_ready) begin
                m_v = 1'b0;
            end
            if (snoop) begin
                foreach (mq[i]) begin
                    if (mq[i].l1 == cdb_in_index) begin mq[i].d1 = cdb_in_result; mq[i].l1 = 0; end
                    if (mq[i].l2 == cdb_in_index) begin mq[i].d2 = cdb_in_result; mq[i].l2 = 0; end
                end
            end
            if (can_disp) begin
                e.op = disp_op; e.d1 = disp_data1; e.l1 = disp_lock1;
                e.d2 = disp_data2; e.l2 = disp_lock2; e.rd = disp_rd_lock;
                if (snoop && e.l1 == cdb_in_index) begin e.d1 = cdb_in_result; e.l1 = 0; end
                if (snoop && e.l2 == cdb_in_index) begin e.d2 = cdb_in_result; e.l2 = 0; end
                mq.push_back(e);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("stall", 64'(disp_stall), 64'(mq.size() == DEPTH));
        check("occ", 64'(occupancy), 64'(mq.size()));
        check("out_vld", 64'(cdb_out_valid), 64'(m_v));
        if (m_v) begin
            check("out_idx", 64'(cdb_out_index), 64'(m_idx));
            check("out_res", 64'(cdb_out_result), 64'(m_res));
        end
    endtask

    task automatic idle();
        disp_valid = 1'b0; disp_op = '0; disp_data1 = '0; disp_lock1 = '0;
        disp_data2 = '0; disp_lock2 = '0; disp_rd_lock = '0;
        cdb_in_valid = 1'b0; cdb_in_index = '0; cdb_in_result = '0;
        cdb_out_ready = 1'b1; flush = 1'b0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] a, input logic [4:0] la,
                        input logic [31:0] b, input logic [4:0] lb, input logic [4:0] rd);
        disp_valid = 1'b1; disp_op = op; disp_data1 = a; disp_lock1 = la;
        disp_data2 = b; disp_lock2 = lb; disp_rd_lock = rd;
    endtask

    logic [3:0]  t_op  [4] = '{4'd10, 4'd3, 4'd4, 4'd8};
    logic [31:0] t_a   [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] t_b   [4] = '{32'h24, 32'd1, 32'd1, 32'd31};
    logic [31:0] t_exp [4] = '{32'hF800_0000, 32'd1, 32'd0, 32'h8000_0000};

    initial begin
        idle();
        repeat (2) @(negedge clk);
        check("rst_vld", 64'(cdb_out_valid), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_stall", 64'(disp_stall), 64'd0);
        check("rst_idx", 64'(cdb_out_index), 64'd0);
        check("rst_res", 64'(cdb_out_result), 64'd0);
        rst = 1'b1;

        // Single ADD: result one edge after the dispatching edge.
        disp(4'd1, 32'd5, 5'd0, 32'd7, 5'd0, 5'd3);
        tick();
        check("add_early", 64'(cdb_out_valid), 64'd0);
        idle();
        tick();
        check("add_vld", 64'(cdb_out_valid), 64'd1);
        check("add_idx", 64'(cdb_out_index), 64'd3);
        check("add_res", 64'(cdb_out_result), 64'd12);
        tick();
        check("add_clr", 64'(cdb_out_valid), 64'd0);

        // Fill, stall, then a single broadcast releases all four in age order.
        for (int k = 0; k < 4; k++) begin
            disp(4'd1, 32'd100, 5'd2, 32'(k), 5'd0, 5'(4 + k));
            tick();
        end
        check("full_stall", 64'(disp_stall), 64'd1);
        check("full_occ", 64'(occupancy), 64'd4);
        disp(4'd1, 32'd0, 5'd0, 32'd0, 5'd0, 5'd8);
        tick();
        check("drop_occ", 64'(occupancy), 64'd4);
        idle();
        cdb_in_valid = 1'b1; cdb_in_index = 5'd2; cdb_in_result = 32'd10;
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("order_idx", 64'(cdb_out_index), 64'(4 + k));
            check("order_res", 64'(cdb_out_result), 64'(10 + k));
        end
        tick();

        // Operand arriving on the CDB in the dispatch cycle itself.
        disp(4'd2, 32'd10, 5'd0, 32'd0, 5'd9, 5'd20);
        cdb_in_valid = 1'b1; cdb_in_index = 5'd9; cdb_in_result = 32'd3;
        tick();
        idle();
        tick();
        check("snoop_vld", 64'(cdb_out_valid), 64'd1);
        check("snoop_res", 64'(cdb_out_result), 64'd7);
        tick();

        // Backpressure hold, then back-to-back drain.
        disp(4'd1, 32'd1, 5'd0, 32'd1, 5'd0, 5'd10);
        tick();
        disp(4'd1, 32'd2, 5'd0, 32'd2, 5'd0, 5'd11);
        cdb_out_ready = 1'b0;
        tick();
        idle();
        cdb_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_idx", 64'(cdb_out_index), 64'd10);
            check("hold_res", 64'(cdb_out_result), 64'd2);
            check("hold_occ", 64'(occupancy), 64'd1);
        end
        cdb_out_ready = 1'b1;
        tick();
        check("b2b_vld", 64'(cdb_out_valid), 64'd1);
        check("b2b_idx", 64'(cdb_out_index), 64'd11);
        tick();

        // Arithmetic corner cases.
        for (int k = 0; k < 4; k++) begin
            disp(t_op[k], t_a[k], 5'd0, t_b[k], 5'd0, 5'd21);
            tick();
            idle();
            tick();
            check("alu_res", 64'(cdb_out_result), 64'(t_exp[k]));
            tick();
        end

        // Flush with three waiting entries and a held output; the concurrent dispatch is dropped.
        idle();
        cdb_out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(4'd1, 32'(k), 5'd0, 32'(k), 5'd0, 5'(12 + k));
            tick();
        end
        check("pre_flush_occ", 64'(occupancy), 64'd3);
        check("pre_flush_vld", 64'(cdb_out_valid), 64'd1);
        disp(4'd1, 32'd9, 5'd0, 32'd9, 5'd0, 5'd16);
        cdb_out_ready = 1'b0;
        flush = 1'b1;
        tick();
        check("flush_occ", 64'(occupancy), 64'd0);
        check("flush_vld", 64'(cdb_out_valid), 64'd0);
        idle();
        tick();

        // Asynchronous reset between edges clears outputs without a clock edge.
        cdb_out_ready = 1'b0;
        disp(4'd1, 32'd3, 5'd0, 32'd3, 5'd0, 5'd17);
        tick();
        disp(4'd1, 32'd4, 5'd0, 32'd4, 5'd0, 5'd18);
        tick();
        idle();
        #2;
        rst = 1'b0;
        #1;
        check("arst_vld", 64'(cdb_out_valid), 64'd0);
        check("arst_occ", 64'(occupancy), 64'd0);
        check("arst_stall", 64'(disp_stall), 64'd0);
        check("arst_res", 64'(cdb_out_result), 64'd0);
        mq.delete();
        m_v = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            disp_valid    = ($urandom_range(0, 3) != 0);
            disp_op       = 4'($urandom_range(0, 15));
            disp_data1    = $urandom;
            disp_lock1    = ($urandom_range(0, 1) != 0) ? 5'd0 : 5'($urandom_range(1, 7));
            disp_data2    = $urandom;
            disp_lock2    = ($urandom_range(0, 1) != 0) ? 5'd0 : 5'($urandom_range(1, 7));
            disp_rd_lock  = 5'($urandom_range(1, 31));
            cdb_in_valid  = ($urandom_range(0, 1) != 0);
            cdb_in_index  = 5'($urandom_range(0, 7));
            cdb_in_result = $urandom;
            cdb_out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
